// File: rtl/median_pkg.sv
// Shared constants and the 3-input ordering helper for the streaming 3x3 median filter.
// sort3 works on comparison results only, so it is independent of pixel width.
package median_pkg;

    localparam int MEDIAN_LATENCY = 3;
    localparam int BORDER_DROP    = 0;
    localparam int BORDER_ZERO    = 1;

    localparam logic [1:0] RANK_LO  = 2'd0;
    localparam logic [1:0] RANK_MID = 2'd1;
    localparam logic [1:0] RANK_HI  = 2'd2;

    // Each field is the index (0=a, 1=b, 2=c) of the operand holding that rank.
    typedef struct packed {
        logic [1:0] hi;
        logic [1:0] mid;
        logic [1:0] lo;
    } sort3_sel_t;

    function automatic sort3_sel_t sort3(input logic b_lt_a, input logic c_lt_a, input logic c_lt_b);
        sort3_sel_t s;
        if (b_lt_a) begin
            s.lo = c_lt_b ? 2'd2 : 2'd1;
            s.hi = c_lt_a ? 2'd0 : 2'd2;
        end else begin
            s.lo = c_lt_a ? 2'd2 : 2'd0;
            s.hi = c_lt_b ? 2'd1 : 2'd2;
        end
        // Indices 0+1+2 sum to 3, so the middle one is whatever is left.
        s.mid = 2'd3 - s.lo - s.hi;
        return s;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: asynchronous read of the old value at addr, write on en.
// Contents are deliberately unreset; every entry is rewritten before it is used.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter over raster-order pixels with a valid/ready interface.
// Window -> column sort -> lows/mids/highs reduce -> final median; the whole pipe stalls on !advance.
module median_filter_stream
    import median_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int BORDER_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam int L = MEDIAN_LATENCY;

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t rank3(input pix_t a, input pix_t b, input pix_t c, input logic [1:0] rank);
        sort3_sel_t s;
        logic [1:0] idx;
        s = sort3(b < a, c < a, c < b);
        case (rank)
            RANK_LO: idx = s.lo;
            RANK_HI: idx = s.hi;
            default: idx = s.mid;
        endcase
        case (idx)
            2'd0:    return a;
            2'd1:    return b;
            default: return c;
        endcase
    endfunction

    logic             advance;
    logic             accept;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             pix_complete;
    logic             pix_last;
    pix_t             lb_row1;
    pix_t             lb_row2;

    logic [2:0][2:0][DATA_W-1:0] win_q;
    logic [2:0][DATA_W-1:0]      lo_q;
    logic [2:0][DATA_W-1:0]      mid_q;
    logic [2:0][DATA_W-1:0]      hi_q;
    pix_t                        max_lo_q;
    pix_t                        med_mid_q;
    pix_t                        min_hi_q;
    logic [L-1:0]                vld_q;
    logic [L-1:0]                cmp_q;
    logic [L-1:0]                eof_q;

    assign advance = !m_valid || m_ready;
    assign s_ready = advance;
    assign accept  = s_valid && advance;

    // A start-of-frame pixel is placed at (0,0) whatever the counters currently say.
    assign pix_col      = s_sof ? '0 : col;
    assign pix_row      = s_sof ? '0 : row;
    assign pix_complete = (pix_col >= COL_W'(2)) && (pix_row >= ROW_W'(2));
    assign pix_last     = (pix_col == COL_LAST) && (pix_row == ROW_LAST);

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_lb_row1 (
        .clk     (clk),
        .en      (accept),
        .addr    (pix_col),
        .wr_data (s_data),
        .rd_data (lb_row1)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(COL_W)) u_lb_row2 (
        .clk     (clk),
        .en      (accept),
        .addr    (pix_col),
        .wr_data (lb_row1),
        .rd_data (lb_row2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_q     <= '0;
            lo_q      <= '0;
            mid_q     <= '0;
            hi_q      <= '0;
            max_lo_q  <= '0;
            med_mid_q <= '0;
            min_hi_q  <= '0;
            vld_q     <= '0;
            cmp_q     <= '0;
            eof_q     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_eof     <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                if (pix_col == COL_LAST) begin
                    col <= '0;
                    row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
                end else begin
                    col <= pix_col + 1'b1;
                    row <= pix_row;
                end
                // win_q[c][r]: c=2 is the newest column, r=2 the current row.
                win_q <= {{s_data, lb_row1, lb_row2}, win_q[2], win_q[1]};
            end

            vld_q <= {vld_q[L-2:0], accept && (BORDER_MODE == BORDER_ZERO || pix_complete)};
            cmp_q <= {cmp_q[L-2:0], pix_complete};
            eof_q <= {eof_q[L-2:0], accept && pix_last};

            for (int c = 0; c < 3; c++) begin
                lo_q[c]  <= rank3(win_q[c][0], win_q[c][1], win_q[c][2], RANK_LO);
                mid_q[c] <= rank3(win_q[c][0], win_q[c][1], win_q[c][2], RANK_MID);
                hi_q[c]  <= rank3(win_q[c][0], win_q[c][1], win_q[c][2], RANK_HI);
            end

            max_lo_q  <= rank3(lo_q[0], lo_q[1], lo_q[2], RANK_HI);
            med_mid_q <= rank3(mid_q[0], mid_q[1], mid_q[2], RANK_MID);
            min_hi_q  <= rank3(hi_q[0], hi_q[1], hi_q[2], RANK_LO);

            m_valid <= vld_q[L-1];
            m_eof   <= eof_q[L-1];
            m_data  <= cmp_q[L-1] ? rank3(max_lo_q, med_mid_q, min_hi_q, RANK_MID) : '0;
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Self-checking bench: two 8x4 instances (drop and zero border) fed the same accepted pixel stream,
// compared against a direct 3x3-median model of each frame.
module tb_median_filter_stream;

    localparam int W = 8;
    localparam int H = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_valid1, s_sof;
    logic [7:0] s_data;
    logic       s_ready0, s_ready1;
    logic       m_valid0, m_valid1;
    logic       m_ready0;
    logic       m_ready1;
    logic [7:0] m_data0, m_data1;
    logic       m_eof0, m_eof1;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rand_ready = 1'b0;
    int   img [H][W];
    exp_t q0[$];
    exp_t q1[$];
    int   got0[$];
    int   got1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    assign s_valid1 = s_valid && s_ready0;
    assign m_ready1 = 1'b1;

    median_filter_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_sof(s_sof),
        .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .m_eof(m_eof0));

    median_filter_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .BORDER_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data), .s_sof(s_sof),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_eof(m_eof1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int med9(input int r, input int c);
        int v[9];
        int k = 0;
        int t;
        for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++) begin
                v[k] = img[r+dr][c+dc];
                k++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    task automatic push_expected(input int n_pix);
        for (int idx = 0; idx < n_pix; idx++) begin
            int  r, c, m;
            bit  cmp, eof;
            r   = idx / W;
            c   = idx % W;
            cmp = (r >= 2) && (c >= 2);
            eof = (idx == W*H - 1);
            m   = cmp ? med9(r, c) : 0;
            if (cmp) q0.push_back('{data: m, eof: eof});
            q1.push_back('{data: m, eof: eof});
        end
    endtask

    task automatic fill(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = val;
                    1: img[r][c] = (r == 2 && c == 3) ? 255 : 0;
                    2: img[r][c] = 10*r + c;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    task automatic send(input int n_pix, input bit bubbles);
        for (int i = 0; i < n_pix; i++) begin
            int guard;
            bit acc;
            guard = 0;
            if (bubbles && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = 8'(img[i / W][i % W]);
            s_sof   = (i == 0);
            do begin
                @(negedge clk);
                acc = s_ready0;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) check("accept_timeout", 32'(acc), 1);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("idle_m_valid0", 32'(m_valid0), 0);
        check("idle_m_valid1", 32'(m_valid1), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid0 && m_ready0) begin
            if (q0.size() == 0) check("dut0_unexpected_output", 32'(m_valid0), 0);
            else begin
                e0 = q0.pop_front();
                check("dut0_data", 32'(m_data0), e0.data);
                check("dut0_eof", 32'(m_eof0), 32'(e0.eof));
                got0.push_back(int'(m_data0));
            end
        end
        if (!rst && m_valid1 && m_ready1) begin
            if (q1.size() == 0) check("dut1_unexpected_output", 32'(m_valid1), 0);
            else begin
                e1 = q1.pop_front();
                check("dut1_data", 32'(m_data1), e1.data);
                check("dut1_eof", 32'(m_eof1), 32'(e1.eof));
                got1.push_back(int'(m_data1));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_ready0 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        int guard;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready0 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_m_valid0", 32'(m_valid0), 0);
        check("rst_m_data0", 32'(m_data0), 0);
        check("rst_m_eof0", 32'(m_eof0), 0);
        check("rst_m_valid1", 32'(m_valid1), 0);
        rst = 1'b0;
        check("rst_s_ready0", 32'(s_ready0), 1);

        // Constant frame, preceded by a single lone pixel used to measure latency on the zero-border path.
        fill(0, 8'h55);
        push_expected(1);
        s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h55;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sof = 1'b0;
        @(negedge clk); check("lat_edge_k", 32'(m_valid1), 0);
        @(negedge clk); check("lat_edge_k1", 32'(m_valid1), 0);
        @(negedge clk); check("lat_edge_k2", 32'(m_valid1), 0);
        @(negedge clk); check("lat_edge_k3", 32'(m_valid1), 1);
        @(posedge clk); #1;
        got0.delete();
        push_expected(W*H);
        send(W*H, 1'b0);
        wait_drain();
        check("const_count", got0.size(), 12);

        // Impulse with random bubbles and random downstream readiness.
        fill(1, 0);
        got0.delete();
        rand_ready = 1'b1;
        push_expected(W*H);
        send(W*H, 1'b1);
        wait_drain();
        rand_ready = 1'b0; m_ready0 = 1'b1;
        check("impulse_count", got0.size(), 12);

        // Ramp, full rate.
        fill(2, 0);
        got0.delete(); got1.delete();
        push_expected(W*H);
        send(W*H, 1'b0);
        wait_drain();
        check("ramp_count0", got0.size(), 12);
        check("ramp_count1", got1.size(), 32);
        if (got0.size() == 12) begin
            check("ramp_first", got0[0], 11);
            check("ramp_last", got0[11], 26);
        end
        if (got1.size() == 32) begin
            check("ramp_b1_r0c0", got1[0], 0);
            check("ramp_b1_r2c1", got1[17], 0);
            check("ramp_b1_r2c2", got1[18], 11);
            check("ramp_b1_r3c7", got1[31], 26);
        end

        // Backpressure mid-frame on the ramp.
        got0.delete();
        push_expected(W*H);
        fork
            send(W*H, 1'b0);
            begin
                guard = 0;
                while (!m_valid0 && guard < 200) begin @(posedge clk); #1; guard++; end
                check("bp_saw_valid", 32'(m_valid0), 1);
                m_ready0 = 1'b0;
                held = m_data0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_s_ready", 32'(s_ready0), 0);
                    check("bp_m_valid", 32'(m_valid0), 1);
                    check("bp_m_data_held", 32'(m_data0), 32'(held));
                    @(posedge clk); #1;
                end
                m_ready0 = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", got0.size(), 12);

        // Truncated frame then a fresh start-of-frame, plus random frames.
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill(3, 0);
            push_expected(5);
            send(5, 1'b1);
            push_expected(W*H);
            send(W*H, 1'b1);
            wait_drain();
        end
        rand_ready = 1'b0; m_ready0 = 1'b1;

        // Reset after 13 pixels, then a clean constant frame.
        fill(0, 8'h55);
        push_expected(13);
        send(13, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_m_valid0", 32'(m_valid0), 0);
        check("midrst_m_valid1", 32'(m_valid1), 0);
        rst = 1'b0;
        q0.delete(); q1.delete();
        check("midrst_s_ready0", 32'(s_ready0), 1);
        got0.delete();
        push_expected(W*H);
        send(W*H, 1'b0);
        wait_drain();
        check("midrst_count", got0.size(), 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/median_filter_stream.md
MEDIAN_FILTER_STREAM -- requirements
Module: median_filter_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the unsigned pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, meaning pixels per line (legal range >=3).
REQ-003 SHALL have parameter IMG_H, default 480, meaning lines per frame (legal range >=3).
REQ-004 SHALL have parameter BORDER_MODE, default 0, meaning 0 = drop incomplete windows and 1 = emit zero for incomplete windows.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-008 SHALL have port s_valid, input, 1 bit, meaning the input pixel is valid.
REQ-009 SHALL have port s_ready, output, 1 bit, meaning the block accepts the input pixel this cycle.
REQ-010 SHALL have port s_data, input, DATA_W bits, the raster-order input pixel.
REQ-011 SHALL have port s_sof, input, 1 bit, meaning the accepted pixel is (col 0, row 0) of a frame.
REQ-012 SHALL have port m_valid, output, 1 bit, meaning the output pixel is valid.
REQ-013 SHALL have port m_ready, input, 1 bit, meaning the downstream accepts the output pixel.
REQ-014 SHALL have port m_data, output, DATA_W bits, the median result.
REQ-015 SHALL have port m_eof, output, 1 bit, meaning the output pixel is the last output of its frame.

Function
REQ-016 SHALL count an input as accepted only on a rising edge with s_valid && s_ready.
REQ-017 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1); each acceptance increments col, wraps col to 0 and increments row at IMG_W-1, and wraps row to 0 after (IMG_W-1, IMG_H-1).
REQ-018 SHALL force the pixel's position to (0,0) when s_sof is accepted, regardless of the counter state, with subsequent counting from there.
REQ-019 SHALL hold two line buffers of IMG_W entries, read-before-write at address col, giving the pixels at rows row-1 and row-2 of the same column.
REQ-020 SHALL shift three 3-entry column registers on each acceptance, forming the window rows row-2..row by cols col-2..col.
REQ-021 SHALL compute the output as the unsigned median (5th of 9) of that window, using a three-stage sort network: sort each column; then max-of-lows, median-of-mids and min-of-highs; then the median of those three.
REQ-022 SHALL mark a window complete when col>=2 && row>=2.
REQ-023 SHALL, with BORDER_MODE 0, not emit incomplete windows, so that (IMG_W-2)*(IMG_H-2) outputs are produced per frame.
REQ-024 SHALL, with BORDER_MODE 1, emit m_data=0 for incomplete windows, so that IMG_W*IMG_H outputs are produced per frame.
REQ-025 SHALL assert m_eof only with the output derived from input (IMG_W-1, IMG_H-1).
REQ-026 SHALL have a latency of 3 cycles: an acceptance at edge k gives m_valid high after edge k+3 when no stall occurs.
REQ-027 SHALL define advance = !m_valid || m_ready, drive s_ready = advance combinationally, and hold every pipeline stage, the line buffers and the counters when advance is 0.
REQ-028 SHALL keep m_data and m_eof stable while m_valid && !m_ready, and lose, duplicate or reorder no pixel.
REQ-029 SHALL propagate pipeline bubbles (cycles with no acceptance) as invalid stages; m_valid SHALL fall after a consumed output when no valid stage follows it.
REQ-030 SHALL sustain one pixel per cycle when s_valid and m_ready are held high.

Reset
REQ-031 SHALL, while rst is high, clear m_valid, m_data, m_eof, col, row, all window registers and all stage-valid bits to 0.
REQ-032 SHALL leave line buffer contents unreset, since they are overwritten before use.
REQ-033 SHALL discard in-flight pixels on a reset mid-frame and restart the next acceptance at (0,0); s_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-034 SHALL place the DATA_W-independent constants (MEDIAN_LATENCY=3, BORDER_DROP=0, BORDER_ZERO=1) and a sort3 helper function in package median_pkg.
REQ-035 SHALL implement the line storage as one sub-module, line_buffer (depth IMG_W, width DATA_W, read-before-write, enable input), instantiated twice.

Verification
REQ-036 SHALL cover a constant frame: 8x4, all 0x55, BORDER_MODE 0 -> exactly 12 outputs, all 0x55, m_eof on the 12th only.
REQ-037 SHALL cover an impulse: 8x4 frame of zeros with 0xFF at (3,2), mode 0 -> all 12 outputs 0x00.
REQ-038 SHALL cover a ramp: 8x4 frame with pixel = 10*row+col, mode 0 -> the first output is 11 and the output for input (7,3) is 26.
REQ-039 SHALL cover backpressure: m_ready low for 5 cycles mid-frame with s_valid high -> s_ready low in the same cycles, m_data held, and a full ordered 12-output sequence.
REQ-040 SHALL cover BORDER_MODE 1: 8x4 ramp -> 32 outputs, with rows 0-1 and cols 0-1 equal to 0 and the rest matching REQ-038.
REQ-041 SHALL cover reset mid-frame: rst pulsed after 13 pixels, then a new frame sent -> m_valid low after the reset edge, and the new frame yields the REQ-036 results.
